// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks: Wishbone register word offsets,
// STATUS register bit positions, the receive FSM state encoding and a helper
// that sizes FIFO occupancy counters.
// ---------------------------------------------------------------------------
package uart_pkg;

    // Word offsets decoded from adr_i[0]
    localparam int REG_RXDATA = 0;
    localparam int REG_STATUS = 1;

    // STATUS register layout
    localparam int STAT_NONEMPTY  = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERRUN   = 2;
    localparam int STAT_FRAME_ERR = 3;
    localparam int STAT_COUNT_LSB = 8;

    // RXDATA register layout: bit 8 flags a valid byte in bits [7:0]
    localparam int RXDATA_VALID = 8;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    // A counter of 0..depth inclusive needs one bit more than the address
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Synchronous single-clock FIFO. A push and a pop in the same cycle both take
// effect even when the FIFO is full, so a reader draining a full FIFO never
// loses the byte arriving on the same edge.
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   push, din        write request and data (ignored when full without pop)
//   pop              read request (ignored when empty)
//   dout             current head entry (valid when !empty)
//   count            number of stored entries, 0..DEPTH
//   full, empty      occupancy flags
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int CW    = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot on the same edge, which lets a push into a full FIFO proceed
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Storage array carries no reset; only the pointers define what is valid
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/wb_uart_rx.sv
// ---------------------------------------------------------------------------
// wb_uart_rx
// Wishbone-slave UART receiver (8N1, LSB first). Received bytes are queued in
// a FIFO; a level interrupt is raised while the FIFO holds data.
//
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   rxd          serial input, idle high, asynchronous to clk
//   cyc_i, stb_i, we_i, sel_i, adr_i, dat_i   Wishbone slave inputs
//                (sel_i ignored, only adr_i[0] decoded)
//   dat_o, ack_o Wishbone read data and single-cycle acknowledge
//   irq          high while the receive FIFO is non-empty
//
// Registers:
//   word 0 RXDATA  read pops {valid, byte}; write ignored
//   word 1 STATUS  [0] non-empty [1] full [2] overrun [3] frame_err
//                  [15:8] count; writing 1 to bit 2/3 clears that flag
// ---------------------------------------------------------------------------
module wb_uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 625,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rxd,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic [29:0] adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic        irq
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int FCW   = count_width(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta;
    logic             rx_s;
    rx_state_t        state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             push_q;
    logic             frame_set_q;
    logic             overrun;
    logic             frame_err;

    logic [7:0]       fifo_dout;
    logic [FCW-1:0]   fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;

    logic             access;
    logic             rd_rxdata;
    logic             wr_status;
    logic             overrun_set;
    logic [31:0]      status_word;
    logic             unused_ok;

    // Two-flop synchronizer, preset high so reset looks like an idle line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_s    <= rx_meta;
        end
    end

    // Receive FSM: half a bit after the start edge we re-check the line to
    // reject glitches, then sample every full bit period at mid-bit. A low
    // stop bit flags a framing error and parks in BREAK until the line
    // returns high, so a held-low line cannot produce a stream of frames.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RX_IDLE;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            push_q      <= 1'b0;
            frame_set_q <= 1'b0;
        end else begin
            push_q      <= 1'b0;
            frame_set_q <= 1'b0;
            unique case (state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        bit_cnt <= HALF_BIT;
                        state   <= RX_START;
                    end
                end
                RX_START: begin
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end else if (!rx_s) begin
                        bit_idx <= '0;
                        bit_cnt <= FULL_BIT;
                        state   <= RX_DATA;
                    end else begin
                        state <= RX_IDLE;
                    end
                end
                RX_DATA: begin
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end else begin
                        shift   <= {rx_s, shift[7:1]};
                        bit_cnt <= FULL_BIT;
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                RX_STOP: begin
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end else if (rx_s) begin
                        push_q <= 1'b1;
                        state  <= RX_IDLE;
                    end else begin
                        frame_set_q <= 1'b1;
                        state       <= RX_BREAK;
                    end
                end
                RX_BREAK: begin
                    if (rx_s) begin
                        state <= RX_IDLE;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    // shift is stable while the FSM sits in IDLE, so the delayed push still sees the byte
    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8),
        .CW    (FCW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_q),
        .din   (shift),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Bus decode: an access is accepted only while ack_o is low, giving one ack per request
    assign access      = cyc_i && stb_i && !ack_o;
    assign rd_rxdata   = access && !we_i && (adr_i[0] == 1'(REG_RXDATA));
    assign wr_status   = access && we_i && (adr_i[0] == 1'(REG_STATUS));
    assign fifo_pop    = rd_rxdata && !fifo_empty;
    assign overrun_set = push_q && fifo_full && !fifo_pop;

    // STATUS word assembled from live flags and occupancy
    always_comb begin
        status_word                             = '0;
        status_word[STAT_NONEMPTY]              = !fifo_empty;
        status_word[STAT_FULL]                  = fifo_full;
        status_word[STAT_OVERRUN]               = overrun;
        status_word[STAT_FRAME_ERR]             = frame_err;
        status_word[STAT_COUNT_LSB +: 8]        = 8'(fifo_count);
    end

    // Sticky error flags: a set in the same cycle as a W1C clear wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= (overrun && !(wr_status && dat_i[STAT_OVERRUN])) || overrun_set;
            frame_err <= (frame_err && !(wr_status && dat_i[STAT_FRAME_ERR])) || frame_set_q;
        end
    end

    // Registered Wishbone response; dat_o is forced to zero whenever ack_o is low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_o <= 1'b0;
            dat_o <= '0;
            irq   <= 1'b0;
        end else begin
            ack_o <= 1'b0;
            dat_o <= '0;
            irq   <= !fifo_empty;
            if (access) begin
                ack_o <= 1'b1;
                if (!we_i) begin
                    if (adr_i[0] == 1'(REG_STATUS)) begin
                        dat_o <= status_word;
                    end else if (!fifo_empty) begin
                        dat_o               <= {23'b0, 1'b1, fifo_dout};
                        dat_o[RXDATA_VALID] <= 1'b1;
                    end
                end
            end
        end
    end

    assign unused_ok = ^{sel_i, adr_i[29:1], dat_i[31:4], dat_i[1:0]};

endmodule

// File: tb/tb_wb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_wb_uart_rx
// Directed self-checking bench for wb_uart_rx with CLKS_PER_BIT=16 and a
// 16-entry FIFO. Each scenario task drives serial frames / bus cycles and
// compares observed values against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_wb_uart_rx;
    import uart_pkg::*;

    localparam int BIT = 16;

    logic        clk;
    logic        reset;
    logic        rxd;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [3:0]  sel_i;
    logic [29:0] adr_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        irq;

    int n_checks;
    int n_fail;

    wb_uart_rx #(
        .CLKS_PER_BIT (BIT),
        .FIFO_DEPTH   (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rxd   (rxd),
        .cyc_i (cyc_i),
        .stb_i (stb_i),
        .we_i  (we_i),
        .sel_i (sel_i),
        .adr_i (adr_i),
        .dat_i (dat_i),
        .dat_o (dat_o),
        .ack_o (ack_o),
        .irq   (irq)
    );

    // 100 MHz-style free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so a stuck run still ends with a visible failure
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance n rising edges and land 1 time unit after the last one
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Serial frame: start, 8 data bits LSB first, optional low stop, idle-high stop
    task automatic send_frame(input logic [7:0] b, input int stop_low);
        rxd = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_clks(BIT);
        end
        if (stop_low > 0) begin
            rxd = 1'b0;
            wait_clks(stop_low);
        end
        rxd = 1'b1;
        wait_clks(BIT);
    endtask

    // Single Wishbone read; reports data and ack at the first and second edge
    task automatic wb_read(input logic adr, output logic [31:0] data,
                           output logic ack1, output logic ack2);
        cyc_i = 1'b1;
        stb_i = 1'b1;
        we_i  = 1'b0;
        adr_i = {29'b0, adr};
        wait_clks(1);
        ack1  = ack_o;
        data  = dat_o;
        cyc_i = 1'b0;
        stb_i = 1'b0;
        wait_clks(1);
        ack2  = ack_o;
    endtask

    // Single Wishbone write
    task automatic wb_write(input logic adr, input logic [31:0] data);
        cyc_i = 1'b1;
        stb_i = 1'b1;
        we_i  = 1'b1;
        adr_i = {29'b0, adr};
        dat_i = data;
        wait_clks(1);
        cyc_i = 1'b0;
        stb_i = 1'b0;
        we_i  = 1'b0;
        dat_i = '0;
        wait_clks(1);
    endtask

    // Idle after reset: outputs quiet, both registers read zero, single-cycle ack
    task automatic test_reset();
        logic [31:0] d;
        logic a1, a2;
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_irq: got %b expected 0", irq); end
        n_checks++; if (ack_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ack: got %b expected 0", ack_o); end
        n_checks++; if (dat_o !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_dat: got %h expected 00000000", dat_o); end
        wb_read(1'b1, d, a1, a2);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_status: got %h expected 00000000", d); end
        wb_read(1'b0, d, a1, a2);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_rxdata: got %h expected 00000000", d); end
        n_checks++; if (a1 !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ack_latency: got %b expected 1", a1); end
        n_checks++; if (a2 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ack_width: got %b expected 0", a2); end
        n_checks++; if (dat_o !== 32'h0) begin n_fail++; $display("[TB] FAIL dat_idle: got %h expected 00000000", dat_o); end
    endtask

    // One clean frame 0xA5 received, read out, FIFO drained
    task automatic test_single_byte();
        logic [31:0] d;
        logic a1, a2;
        send_frame(8'hA5, 0);
        wait_clks(4);
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("[TB] FAIL a5_irq: got %b expected 1", irq); end
        wb_read(1'b1, d, a1, a2);
        n_checks++; if (d !== 32'h0000_0101) begin n_fail++; $display("[TB] FAIL a5_status: got %h expected 00000101", d); end
        wb_read(1'b0, d, a1, a2);
        n_checks++; if (d !== 32'h0000_01A5) begin n_fail++; $display("[TB] FAIL a5_rxdata: got %h expected 000001a5", d); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL a5_irq_clear: got %b expected 0", irq); end
        wb_read(1'b1, d, a1, a2);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("[TB] FAIL a5_status_after: got %h expected 00000000", d); end
    endtask

    // Short low pulse is rejected at the half-bit re-check
    task automatic test_glitch();
        logic [31:0] d;
        logic a1, a2;
        rxd = 1'b0;
        wait_clks(6);
        rxd = 1'b1;
        wait_clks(30);
        n_checks++; if (dut.state !== RX_IDLE) begin n_fail++; $display("[TB] FAIL glitch_state: got %0d expected %0d", dut.state, RX_IDLE); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL glitch_irq: got %b expected 0", irq); end
        wb_read(1'b1, d, a1, a2);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("[TB] FAIL glitch_status: got %h expected 00000000", d); end
    endtask

    // Low stop bit flags frame_err and drops the byte; next frame still received
    task automatic test_frame_error();
        logic [31:0] d;
        logic a1, a2;
        send_frame(8'h3C, 40);
        wait_clks(4);
        wb_read(1'b1, d, a1, a2);
        n_checks++; if (d !== 32'h0000_0008) begin n_fail++; $display("[TB] FAIL ferr_status: got %h expected 00000008", d); end
        send_frame(8'h55, 0);
        wait_clks(4);
        wb_read(1'b1, d, a1, a2);
        n_checks++; if (d !== 32'h0000_0109) begin n_fail++; $display("[TB] FAIL ferr_status2: got %h expected 00000109", d); end
        wb_read(1'b0, d, a1, a2);
        n_checks++; if (d !== 32'h0000_0155) begin n_fail++; $display("[TB] FAIL ferr_rxdata: got %h expected 00000155", d); end
        wb_write(1'b1, 32'h0000_0008);
        wb_read(1'b1, d, a1, a2);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("[TB] FAIL ferr_clear: got %h expected 00000000", d); end
    endtask

    // 17 frames into a 16-deep FIFO: full plus overrun, then in-order drain
    task automatic test_overrun();
        logic [31:0] d;
        logic a1, a2;
        for (int i = 0; i <= 16; i++) begin
            send_frame(8'(i), 0);
        end
        wait_clks(4);
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("[TB] FAIL ovr_irq: got %b expected 1", irq); end
        wb_read(1'b1, d, a1, a2);
        n_checks++; if (d !== 32'h0000_1007) begin n_fail++; $display("[TB] FAIL ovr_status: got %h expected 00001007", d); end
        for (int i = 0; i < 16; i++) begin
            wb_read(1'b0, d, a1, a2);
            n_checks++; if (d !== (32'h100 + 32'(i))) begin n_fail++; $display("[TB] FAIL ovr_read%0d: got %h expected %h", i, d, 32'h100 + 32'(i)); end
        end
        wb_read(1'b0, d, a1, a2);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("[TB] FAIL ovr_empty_read: got %h expected 00000000", d); end
        wb_read(1'b1, d, a1, a2);
        n_checks++; if (d !== 32'h0000_0004) begin n_fail++; $display("[TB] FAIL ovr_sticky: got %h expected 00000004", d); end
        wb_write(1'b1, 32'h0000_0004);
        wb_read(1'b1, d, a1, a2);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("[TB] FAIL ovr_clear: got %h expected 00000000", d); end
    endtask

    // Reset in the middle of data bit 4 discards the partial frame
    task automatic test_reset_midframe();
        logic [31:0] d;
        logic a1, a2;
        rxd = 1'b0;
        wait_clks(BIT);
        wait_clks(BIT * 4 + 8);
        n_checks++; if (dut.state !== RX_DATA) begin n_fail++; $display("[TB] FAIL mid_state: got %0d expected %0d", dut.state, RX_DATA); end
        reset = 1'b1;
        wait_clks(3);
        n_checks++; if (dut.state !== RX_IDLE) begin n_fail++; $display("[TB] FAIL mid_reset_state: got %0d expected %0d", dut.state, RX_IDLE); end
        rxd = 1'b1;
        wait_clks(1);
        reset = 1'b0;
        wait_clks(10);
        send_frame(8'h81, 0);
        wait_clks(4);
        wb_read(1'b1, d, a1, a2);
        n_checks++; if (d !== 32'h0000_0101) begin n_fail++; $display("[TB] FAIL mid_status: got %h expected 00000101", d); end
        wb_read(1'b0, d, a1, a2);
        n_checks++; if (d !== 32'h0000_0181) begin n_fail++; $display("[TB] FAIL mid_rxdata: got %h expected 00000181", d); end
        wb_read(1'b1, d, a1, a2);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("[TB] FAIL mid_status_after: got %h expected 00000000", d); end
    endtask

    // Scenario sequence
    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        rxd      = 1'b1;
        cyc_i    = 1'b0;
        stb_i    = 1'b0;
        we_i     = 1'b0;
        sel_i    = 4'hF;
        adr_i    = '0;
        dat_i    = '0;
        wait_clks(3);
        reset = 1'b0;
        wait_clks(3);
        $display("[TB] test_reset");
        test_reset();
        $display("[TB] test_single_byte");
        test_single_byte();
        $display("[TB] test_glitch");
        test_glitch();
        $display("[TB] test_frame_error");
        test_frame_error();
        $display("[TB] test_overrun");
        test_overrun();
        $display("[TB] test_reset_midframe");
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
